// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: response codes and channel state encodings shared by the AXI4-Lite arbiter
package axi4lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_BWAIT, W_RESP} w_state_t;
endpackage

// File: rtl/axi4lite_rr_arbiter.sv
// axi4lite_rr_arbiter: combinational round-robin pick, searching from the requester after ptr
module axi4lite_rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] j;
  logic found;
  // walk ptr+1 .. ptr+N (mod N) and take the first active request
  always_comb begin
    grant = '0;
    idx = ptr;
    found = 1'b0;
    j = '0;
    for (int i = 1; i <= N; i++) begin
      j = PW'((int'(ptr) + i) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/axi4lite_arbiter.sv
// axi4lite_arbiter: N-to-1 AXI4-Lite arbiter, independent read/write channels; AXI4LITE_ARB_TIMEOUT_EN adds a response watchdog
module axi4lite_arbiter
  import axi4lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_areset,
  input  logic [NUM_REQ-1:0][31:0]   s_axi_araddr,
  input  logic [NUM_REQ-1:0]         s_axi_arvalid,
  output logic [NUM_REQ-1:0]         s_axi_arready,
  output logic [31:0]                s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic [NUM_REQ-1:0]         s_axi_rvalid,
  input  logic [NUM_REQ-1:0]         s_axi_rready,
  input  logic [NUM_REQ-1:0][31:0]   s_axi_awaddr,
  input  logic [NUM_REQ-1:0]         s_axi_awvalid,
  output logic [NUM_REQ-1:0]         s_axi_awready,
  input  logic [NUM_REQ-1:0][31:0]   s_axi_wdata,
  input  logic [NUM_REQ-1:0][3:0]    s_axi_wstrb,
  input  logic [NUM_REQ-1:0]         s_axi_wvalid,
  output logic [NUM_REQ-1:0]         s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic [NUM_REQ-1:0]         s_axi_bvalid,
  input  logic [NUM_REQ-1:0]         s_axi_bready,
  output logic [31:0]                m_axi_araddr,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [31:0]                m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic [31:0]                m_axi_awaddr,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [31:0]                m_axi_wdata,
  output logic [3:0]                 m_axi_wstrb,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready
);
  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("axi4lite_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  r_state_t r_state;
  w_state_t w_state;
  logic [PW-1:0] r_ptr, r_g, rd_idx, w_ptr, w_g, wr_idx;
  logic [NUM_REQ-1:0] rd_gnt, wr_gnt, wr_req;
  logic aw_done, w_done;

  assign wr_req = s_axi_awvalid & s_axi_wvalid;

  axi4lite_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (.req(s_axi_arvalid), .ptr(r_ptr), .grant(rd_gnt), .idx(rd_idx));
  axi4lite_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (.req(wr_req), .ptr(w_ptr), .grant(wr_gnt), .idx(wr_idx));

  assign s_axi_arready = (r_state == R_IDLE) ? rd_gnt : '0;
  assign s_axi_awready = (w_state == W_IDLE) ? wr_gnt : '0;
  assign s_axi_wready  = (w_state == W_IDLE) ? wr_gnt : '0;
  assign s_axi_rvalid  = {NUM_REQ{r_state == R_RESP}} & (NUM_REQ'(1) << r_g);
  assign s_axi_bvalid  = {NUM_REQ{w_state == W_RESP}} & (NUM_REQ'(1) << w_g);
  assign m_axi_arvalid = r_state == R_ADDR;
  assign m_axi_rready  = r_state == R_DATA;
  assign m_axi_awvalid = w_state == W_ADDR && !aw_done;
  assign m_axi_wvalid  = w_state == W_ADDR && !w_done;
  assign m_axi_bready  = w_state == W_BWAIT;

`ifdef AXI4LITE_ARB_TIMEOUT_EN
  logic [31:0] r_cnt, w_cnt;
  logic r_wait, w_wait;
  assign r_wait = r_state == R_ADDR || r_state == R_DATA;
  assign w_wait = w_state == W_ADDR || w_state == W_BWAIT;
`endif

  // read channel: grant, forward address, collect data, hold response for the winner
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state <= R_IDLE;
      r_ptr <= PW'(NUM_REQ - 1);
      r_g <= '0;
      m_axi_araddr <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
      r_cnt <= '0;
`endif
    end else begin
      case (r_state)
        R_IDLE: if (|s_axi_arvalid) begin
          r_g <= rd_idx;
          m_axi_araddr <= s_axi_araddr[rd_idx];
          r_state <= R_ADDR;
        end
        R_ADDR: if (m_axi_arready) r_state <= R_DATA;
        R_DATA: if (m_axi_rvalid) begin
          s_axi_rdata <= m_axi_rdata;
          s_axi_rresp <= m_axi_rresp;
          r_state <= R_RESP;
        end
        R_RESP: if (s_axi_rready[r_g]) begin
          r_ptr <= r_g;
          r_state <= R_IDLE;
        end
      endcase
`ifdef AXI4LITE_ARB_TIMEOUT_EN
      r_cnt <= r_wait ? r_cnt + 32'd1 : '0;
      if (r_wait && r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        s_axi_rdata <= '0;
        s_axi_rresp <= RESP_SLVERR;
        r_state <= R_RESP;
      end
`endif
    end
  end

  // write channel: grant AW+W together, forward each until accepted, relay B to the winner
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state <= W_IDLE;
      w_ptr <= PW'(NUM_REQ - 1);
      w_g <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_wdata <= '0;
      m_axi_wstrb <= '0;
      s_axi_bresp <= RESP_OKAY;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
      w_cnt <= '0;
`endif
    end else begin
      case (w_state)
        W_IDLE: if (|wr_req) begin
          w_g <= wr_idx;
          m_axi_awaddr <= s_axi_awaddr[wr_idx];
          m_axi_wdata <= s_axi_wdata[wr_idx];
          m_axi_wstrb <= s_axi_wstrb[wr_idx];
          aw_done <= 1'b0;
          w_done <= 1'b0;
          w_state <= W_ADDR;
        end
        W_ADDR: begin
          aw_done <= aw_done | m_axi_awready;
          w_done <= w_done | m_axi_wready;
          if ((aw_done | m_axi_awready) && (w_done | m_axi_wready)) w_state <= W_BWAIT;
        end
        W_BWAIT: if (m_axi_bvalid) begin
          s_axi_bresp <= m_axi_bresp;
          w_state <= W_RESP;
        end
        W_RESP: if (s_axi_bready[w_g]) begin
          w_ptr <= w_g;
          w_state <= W_IDLE;
        end
      endcase
`ifdef AXI4LITE_ARB_TIMEOUT_EN
      w_cnt <= w_wait ? w_cnt + 32'd1 : '0;
      if (w_wait && w_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        s_axi_bresp <= RESP_SLVERR;
        w_state <= W_RESP;
      end
`endif
    end
  end
endmodule

// File: tb/tb_axi4lite_arbiter.sv
// tb_axi4lite_arbiter: directed vectors for the AXI4-Lite arbiter; timeout case only when AXI4LITE_ARB_TIMEOUT_EN is defined
module tb_axi4lite_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0][31:0] araddr, awaddr, wdata;
  logic [3:0][3:0] wstrb;
  logic [3:0] arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] rdata, m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [1:0] rresp, bresp, m_rresp, m_bresp;
  logic [3:0] m_wstrb;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  int n_vec = 0;
  int n_err = 0;

  axi4lite_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
    m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
    m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
    for (int i = 0; i < 4; i++) begin
      awaddr[i] = 32'h1000 + 32'(16 * i);
      wdata[i] = 32'hA0 + 32'(i);
      wstrb[i] = 4'hF;
    end
    #3;
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_mvalid", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 0);
    chk("rst_resp", 32'({rdata, rresp, bresp}), 0);
    #9 rst = 1'b0;

    // two readers at once: 0 first, then 2
    step();
    arvalid = 4'b0101; araddr[0] = 32'h100; araddr[2] = 32'h200;
    settle();
    chk("rd_gnt0", 32'(arready), 32'b0001);
    step();
    arvalid[0] = 1'b0; m_arready = 1;
    settle();
    chk("rd_addr0", m_araddr, 32'h100);
    chk("rd_arv0", 32'({m_arvalid, arready}), 32'b1_0000);
    step();
    m_arready = 0; m_rvalid = 1; m_rdata = 32'h1234; m_rresp = 2'b00;
    settle();
    chk("rd_rready", 32'(m_rready), 1);
    step();
    m_rvalid = 0;
    settle();
    chk("rd_rvalid0", 32'(rvalid), 32'b0001);
    chk("rd_data0", rdata, 32'h1234);
    rready[0] = 1;
    step();
    rready[0] = 0;
    settle();
    chk("rd_gnt2", 32'(arready), 32'b0100);
    step();
    arvalid[2] = 1'b0; m_arready = 1;
    settle();
    chk("rd_addr2", m_araddr, 32'h200);
    step();
    m_arready = 0; m_rvalid = 1; m_rdata = 32'h5678;
    step();
    m_rvalid = 0;
    settle();
    chk("rd_rvalid2", 32'(rvalid), 32'b0100);
    chk("rd_data2", rdata, 32'h5678);
    rready[2] = 1;
    step();
    rready[2] = 0;
    settle();
    chk("rd_done", 32'(rvalid), 0);

    // all four writers hammering: 0,1,2,3,0
    awvalid = 4'hF; wvalid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("wr_awgnt", 32'(awready), 32'(1) << (k % 4));
      chk("wr_wgnt", 32'(wready), 32'(1) << (k % 4));
      chk("wr_bidle", 32'(bvalid), 0);
      step();
      m_awready = 1; m_wready = 1;
      settle();
      chk("wr_addr", m_awaddr, 32'h1000 + 32'(16 * (k % 4)));
      chk("wr_nogrant", 32'({awready, wready}), 0);
      step();
      m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 2'b00;
      settle();
      chk("wr_bready", 32'(m_bready), 1);
      step();
      m_bvalid = 0; bready = 4'hF;
      settle();
      chk("wr_bvalid", 32'(bvalid), 32'(1) << (k % 4));
      step();
      bready = '0;
      if (k == 4) begin
        awvalid = '0; wvalid = '0;
      end
    end

    // requester 1 reads and writes together
    arvalid[1] = 1; araddr[1] = 32'h300; awvalid[1] = 1; wvalid[1] = 1;
    settle();
    chk("rw_gnt", 32'({arready, awready}), 32'b0010_0010);
    step();
    arvalid = '0; awvalid = '0; wvalid = '0;
    settle();
    chk("rw_concurrent", 32'({m_arvalid, m_awvalid, m_wvalid}), 32'b111);
    m_arready = 1; m_awready = 1; m_wready = 1;
    step();
    m_arready = 0; m_awready = 0; m_wready = 0;
    m_rvalid = 1; m_rdata = 32'hCAFE; m_rresp = 2'b00; m_bvalid = 1; m_bresp = 2'b10;
    step();
    m_rvalid = 0; m_bvalid = 0;
    settle();
    chk("rw_valids", 32'({rvalid, bvalid}), 32'b0010_0010);
    chk("rw_rdata", rdata, 32'hCAFE);
    chk("rw_bresp", 32'(bresp), 32'b10);
    rready[1] = 1; bready[1] = 1;
    step();
    rready = '0; bready = '0;

    // AW accepted in the first cycle, W only in the fourth
    awvalid[2] = 1; wvalid[2] = 1; awaddr[2] = 32'h3000; wdata[2] = 32'hDEADBEEF; wstrb[2] = 4'b0101;
    settle();
    chk("sp_gnt", 32'(awready), 32'b0100);
    step();
    awvalid = '0; wvalid = '0; m_awready = 1;
    settle();
    chk("sp_c1", 32'({m_awvalid, m_wvalid}), 32'b11);
    chk("sp_wdata", m_wdata, 32'hDEADBEEF);
    chk("sp_wstrb", 32'(m_wstrb), 32'b0101);
    step();
    m_awready = 0;
    settle();
    chk("sp_c2", 32'({m_awvalid, m_wvalid}), 32'b01);
    step();
    chk("sp_c3", 32'({m_awvalid, m_wvalid}), 32'b01);
    step();
    m_wready = 1;
    settle();
    chk("sp_c4", 32'({m_awvalid, m_wvalid}), 32'b01);
    step();
    m_wready = 0;
    settle();
    chk("sp_bwait", 32'({m_awvalid, m_wvalid, m_bready}), 32'b001);
    m_bvalid = 1; m_bresp = 2'b00;
    step();
    m_bvalid = 0;
    settle();
    chk("sp_bvalid", 32'(bvalid), 32'b0100);
    chk("sp_bresp", 32'(bresp), 0);
    bready[2] = 1;
    step();
    bready = '0;
    settle();
    chk("sp_single", 32'(bvalid), 0);

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    // read with a silent downstream completes as SLVERR after 8 waiting cycles
    begin
      int n;
      n = 0;
      arvalid[3] = 1; araddr[3] = 32'h4000;
      settle();
      chk("to_gnt", 32'(arready), 32'b1000);
      step();
      arvalid = '0; m_arready = 1;
      step();
      m_arready = 0;
      for (int i = 0; i < 30 && rvalid == '0; i++) begin
        step();
        n++;
      end
      chk("to_rvalid", 32'(rvalid), 32'b1000);
      chk("to_lat", 32'(n), 7);
      chk("to_rresp", 32'(rresp), 32'b10);
      chk("to_rdata", rdata, 0);
      chk("to_rready", 32'(m_rready), 0);
      rready[3] = 1;
      step();
      rready = '0;
      arvalid[0] = 1; araddr[0] = 32'h50;
      settle();
      chk("to_next_gnt", 32'(arready), 32'b0001);
      step();
      arvalid = '0; m_arready = 1;
      step();
      m_arready = 0; m_rvalid = 1; m_rdata = 32'h42; m_rresp = 2'b00;
      step();
      m_rvalid = 0;
      settle();
      chk("to_next_rv", 32'(rvalid), 32'b0001);
      chk("to_next_data", rdata, 32'h42);
      chk("to_next_resp", 32'(rresp), 0);
      rready[0] = 1;
      step();
      rready = '0;
    end
`endif

    // reset while waiting for B abandons the write
    awvalid[1] = 1; wvalid[1] = 1;
    settle();
    chk("rs_gnt", 32'(awready), 32'b0010);
    step();
    awvalid = '0; wvalid = '0; m_awready = 1; m_wready = 1;
    step();
    m_awready = 0; m_wready = 0;
    settle();
    chk("rs_bwait", 32'(m_bready), 1);
    rst = 1'b1;
    #1;
    chk("rs_bready", 32'({m_bready, m_awvalid, m_wvalid, m_arvalid, m_rready}), 0);
    chk("rs_svalid", 32'({bvalid, rvalid, awready, arready}), 0);
    chk("rs_rdata", rdata, 0);
    #2 rst = 1'b0;
    awvalid = 4'hF; wvalid = 4'hF;
    settle();
    chk("rs_regnt", 32'(awready), 32'b0001);
    step();
    awvalid = '0; wvalid = '0;
    settle();
    chk("rs_nob", 32'(bvalid), 0);
    chk("rs_newaddr", m_awaddr, 32'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi4lite_arbiter.md
AXI4LITE_ARBITER -- requirements
Module: axi4lite_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of upstream requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the downstream response watchdog limit (only with the timeout feature).
REQ-003 SHALL have port s_axi_aclk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port s_axi_areset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have per-requester read slave ports s_axi_araddr[NUM_REQ][32] in, s_axi_arvalid[NUM_REQ] in, s_axi_arready[NUM_REQ] out, s_axi_rdata[32] out (shared), s_axi_rresp[2] out (shared), s_axi_rvalid[NUM_REQ] out, s_axi_rready[NUM_REQ] in.
REQ-006 SHALL have per-requester write slave ports s_axi_awaddr[NUM_REQ][32], s_axi_awvalid, s_axi_wdata[NUM_REQ][32], s_axi_wstrb[NUM_REQ][4], s_axi_wvalid, s_axi_bready in; s_axi_awready, s_axi_wready, s_axi_bvalid[NUM_REQ] out; s_axi_bresp[2] out (shared).
REQ-007 SHALL have one downstream master port (to interconnect): m_axi_araddr[32], m_axi_arvalid, m_axi_rready, m_axi_awaddr[32], m_axi_awvalid, m_axi_wdata[32], m_axi_wstrb[4], m_axi_wvalid, m_axi_bready out; m_axi_arready, m_axi_rdata[32], m_axi_rresp[2], m_axi_rvalid, m_axi_awready, m_axi_wready, m_axi_bresp[2], m_axi_bvalid in.

Function
REQ-008 SHALL arbitrate reads and writes independently; at most one outstanding read and one outstanding write.
REQ-009 SHALL use round-robin per channel: search starts at (last_grant+1) mod NUM_REQ; pointer updates only on transaction completion.
REQ-010 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA, R_RESP.
REQ-011 R_IDLE: if any arvalid, s_axi_arready[g]=1 combinationally for winner g only; address and g captured; next state R_ADDR.
REQ-012 R_ADDR: m_axi_arvalid=1 with captured address, held until m_axi_arready; then R_DATA.
REQ-013 R_DATA: m_axi_rready=1; on m_axi_rvalid capture rdata/rresp; then R_RESP.
REQ-014 R_RESP: s_axi_rvalid[g]=1 with captured data until s_axi_rready[g]; then R_IDLE, pointer=g; minimum read latency arvalid->rvalid 3 cycles.
REQ-015 Write FSM SHALL have states W_IDLE, W_ADDR, W_BWAIT, W_RESP; a requester is eligible only with awvalid and wvalid both high.
REQ-016 W_IDLE: winner gets s_axi_awready and s_axi_wready in the same cycle; addr/data/strb captured.
REQ-017 W_ADDR: m_axi_awvalid and m_axi_wvalid asserted, each dropped independently on its ready; leave to W_BWAIT when both accepted (same or different cycles).
REQ-018 W_BWAIT: m_axi_bready=1; capture bresp on m_axi_bvalid; W_RESP holds s_axi_bvalid[g] until s_axi_bready[g].
REQ-019 A requester dropping valid before grant SHALL lose nothing; non-granted requesters see ready=0.

Reset
REQ-020 On s_axi_areset, asynchronously: both FSMs idle, pointers=NUM_REQ-1 (first grant to requester 0), all valid/ready outputs 0, rdata=0, rresp=bresp=2'b00, timeout counter 0.
REQ-021 Reset mid-transaction SHALL abandon it without any response on either side.

Configuration
REQ-022 Macro AXI4LITE_ARB_TIMEOUT_EN defined: counter runs in R_ADDR/R_DATA and W_ADDR/W_BWAIT; on reaching TIMEOUT_CYCLES, drop downstream valid/ready and go to R_RESP/W_RESP with resp=2'b10 (SLVERR), rdata=0; late downstream responses ignored.
REQ-023 Macro undefined: no counter, no TIMEOUT_CYCLES effect, FSMs wait indefinitely.

Structure
REQ-024 Package axi4lite_pkg SHALL hold resp constants (OKAY=2'b00, SLVERR=2'b10) and read/write state enums.
REQ-025 Sub-module axi4lite_rr_arbiter (request vector, pointer -> one-hot grant, combinational) SHALL be instantiated twice.

Verification
REQ-026 Req0 and req2 arvalid same cycle, pointer reset -> req0 granted first, req2 second; rdata 0x1234 and 0x5678 routed to correct rvalid.
REQ-027 All 4 requesters continuously issue writes -> grant order 0,1,2,3,0; each bvalid once per grant.
REQ-028 Read and write simultaneously from req1 -> both forwarded concurrently; m_axi_arvalid and m_axi_awvalid high same cycle.
REQ-029 m_axi_awready at cycle 1, m_axi_wready at cycle 4 -> awvalid drops after cycle 1, wvalid after cycle 4, single B response.
REQ-030 Timeout build, TIMEOUT_CYCLES=8, downstream never asserts rvalid -> s_axi_rresp=2'b10, rdata=0, next read served normally.
REQ-031 s_axi_areset asserted in W_BWAIT -> all outputs 0 immediately; after release, new write granted to requester 0.
